// File: rtl/ttt_pkg.sv
// Shared encodings, line table and small helpers for the tic-tac-toe controller.
package ttt_pkg;

   localparam int unsigned CELL_W    = 2;
   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned NUM_LINES = 8;
   localparam int unsigned CUR_W     = 4;
   localparam int unsigned TMR_W     = 32;

   localparam logic [CELL_W-1:0] EMPTY = 2'b00;
   localparam logic [CELL_W-1:0] P1    = 2'b01;
   localparam logic [CELL_W-1:0] P2    = 2'b10;

   localparam logic [CUR_W-1:0] CURSOR_HOME = 4'd5;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'b00,
      ST_CHECK = 2'b01,
      ST_WIN   = 2'b10,
      ST_DRAW  = 2'b11
   } game_state_t;

   // Zero-based cell indices of the 3 rows, 3 columns and 2 diagonals
   localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [CELL_W-1:0] other_player(input logic [CELL_W-1:0] p);
      return (p == P1) ? P2 : P1;
   endfunction

   // One cursor step with row/column wrap; priority up > down > left > right
   function automatic logic [CUR_W-1:0] cursor_move(input logic [CUR_W-1:0] cur,
                                                    input logic up, input logic down,
                                                    input logic left, input logic right);
      logic [CUR_W-1:0] nxt;
      nxt = cur;
      if (up)
         nxt = (cur <= 4'd3) ? 4'(cur + 4'd6) : 4'(cur - 4'd3);
      else if (down)
         nxt = (cur >= 4'd7) ? 4'(cur - 4'd6) : 4'(cur + 4'd3);
      else if (left)
         nxt = (cur == 4'd1 || cur == 4'd4 || cur == 4'd7) ? 4'(cur + 4'd2) : 4'(cur - 4'd1);
      else if (right)
         nxt = (cur == 4'd3 || cur == 4'd6 || cur == 4'd9) ? 4'(cur - 4'd2) : 4'(cur + 4'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational board evaluation: any completed line, its owner, and board-full flag.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [17:0] cells,
   output logic        win_c,
   output logic [1:0]  win_code_c,
   output logic        full_c
);

   logic [CELL_W-1:0] a, b, c;

   always_comb begin
      win_c      = 1'b0;
      win_code_c = EMPTY;
      full_c     = 1'b1;
      a          = EMPTY;
      b          = EMPTY;
      c          = EMPTY;
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
         if (cells[CELL_W*i +: CELL_W] == EMPTY) full_c = 1'b0;
      end
      for (int l = 0; l < int'(NUM_LINES); l++) begin
         a = cells[CELL_W*int'(LINE_TBL[l][0]) +: CELL_W];
         b = cells[CELL_W*int'(LINE_TBL[l][1]) +: CELL_W];
         c = cells[CELL_W*int'(LINE_TBL[l][2]) +: CELL_W];
         if (!win_c && a != EMPTY && a == b && b == c) begin
            win_c      = 1'b1;
            win_code_c = a;
         end
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board, cursor, turn timer and PLAY/CHECK/WIN/DRAW sequencing.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter logic [1:0]  FIRST_PLAYER = 2'b01,
   parameter logic [31:0] TURN_TIMEOUT = 32'd250_000_000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   input  logic       btn_new,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [3:0] cursor,
   output logic [1:0] turn,
   output logic [1:0] game_state,
   output logic [1:0] winner
);

   game_state_t                          state, state_nx;
   logic [NUM_CELLS-1:0][CELL_W-1:0]     board, board_nx;
   logic [CUR_W-1:0]                     cursor_q, cursor_nx;
   logic [CELL_W-1:0]                    turn_q, turn_nx;
   logic [CELL_W-1:0]                    winner_q, winner_nx;
   logic [TMR_W-1:0]                     timer, timer_nx;
   logic [CUR_W-1:0]                     cur_idx;
   logic                                 accepted;
   logic                                 win_c, full_c;
   logic [CELL_W-1:0]                    win_code_c;

   ttt_line_check u_line_check (
      .cells      (board),
      .win_c      (win_c),
      .win_code_c (win_code_c),
      .full_c     (full_c)
   );

   assign cur_idx = 4'(cursor_q - 4'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_PLAY;
         board    <= '0;
         cursor_q <= CURSOR_HOME;
         turn_q   <= FIRST_PLAYER;
         winner_q <= EMPTY;
         timer    <= TURN_TIMEOUT;
      end else begin
         state    <= state_nx;
         board    <= board_nx;
         cursor_q <= cursor_nx;
         turn_q   <= turn_nx;
         winner_q <= winner_nx;
         timer    <= timer_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      board_nx  = board;
      cursor_nx = cursor_q;
      turn_nx   = turn_q;
      winner_nx = winner_q;
      timer_nx  = TURN_TIMEOUT;
      accepted  = 1'b0;
      if (btn_new) begin
         state_nx  = ST_PLAY;
         board_nx  = '0;
         cursor_nx = CURSOR_HOME;
         turn_nx   = FIRST_PLAYER;
         winner_nx = EMPTY;
      end else begin
         case (state)
            ST_PLAY: begin
               timer_nx = timer;
               // A select always swallows any same-cycle direction pulse
               if (btn_sel) begin
                  if (board[cur_idx] == EMPTY) begin
                     board_nx[cur_idx] = turn_q;
                     state_nx          = ST_CHECK;
                     timer_nx          = TURN_TIMEOUT;
                     accepted          = 1'b1;
                  end
               end else begin
                  cursor_nx = cursor_move(cursor_q, btn_up, btn_down, btn_left, btn_right);
               end
               if (!accepted && TURN_TIMEOUT != 32'd0) begin
                  if (timer == 32'd0) begin
                     turn_nx  = other_player(turn_q);
                     timer_nx = TURN_TIMEOUT;
                  end else begin
                     timer_nx = 32'(timer - 32'd1);
                  end
               end
            end
            ST_CHECK: begin
               if (win_c) begin
                  state_nx  = ST_WIN;
                  winner_nx = win_code_c;
               end else if (full_c) begin
                  state_nx = ST_DRAW;
               end else begin
                  state_nx = ST_PLAY;
                  turn_nx  = other_player(turn_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = board;
   assign cursor     = cursor_q;
   assign turn       = turn_q;
   assign game_state = state;
   assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a cycle model predicts each edge, a monitor compares.
module tb_ttt_game_ctrl;

   localparam int TO = 10;
   localparam logic [5:0] B_NONE  = 6'b000000;
   localparam logic [5:0] B_NEW   = 6'b100000;
   localparam logic [5:0] B_SEL   = 6'b010000;
   localparam logic [5:0] B_UP    = 6'b001000;
   localparam logic [5:0] B_DOWN  = 6'b000100;
   localparam logic [5:0] B_LEFT  = 6'b000010;
   localparam logic [5:0] B_RIGHT = 6'b000001;

   logic clk, reset;
   logic btn_up, btn_down, btn_left, btn_right, btn_sel, btn_new;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [3:0] cursor;
   logic [1:0] turn, game_state, winner;

   ttt_game_ctrl #(.FIRST_PLAYER(2'b01), .TURN_TIMEOUT(32'd10)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_sel(btn_sel), .btn_new(btn_new),
      .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
      .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
      .cursor(cursor), .turn(turn), .game_state(game_state), .winner(winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int step_id = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model
   logic [1:0] m_b [9];
   int         m_cur;
   logic [1:0] m_turn, m_gs, m_win;
   int         m_tmr;
   int         lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                                '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

   task automatic m_reset();
      for (int i = 0; i < 9; i++) m_b[i] = 2'b00;
      m_cur = 5; m_turn = 2'b01; m_gs = 2'b00; m_win = 2'b00; m_tmr = TO;
   endtask

   function automatic logic [1:0] m_line_winner();
      logic [1:0] w;
      w = 2'b00;
      for (int l = 7; l >= 0; l--) begin
         if (m_b[lines[l][0]-1] != 2'b00 && m_b[lines[l][0]-1] == m_b[lines[l][1]-1] &&
             m_b[lines[l][1]-1] == m_b[lines[l][2]-1])
            w = m_b[lines[l][0]-1];
      end
      return w;
   endfunction

   function automatic logic [1:0] m_flip(input logic [1:0] p);
      return (p == 2'b01) ? 2'b10 : 2'b01;
   endfunction

   task automatic m_step(input logic [5:0] b);
      logic acc, full;
      logic [1:0] w;
      int r, c;
      if (b[5]) begin
         m_reset();
      end else if (m_gs == 2'b00) begin
         acc = 1'b0;
         r = (m_cur - 1) / 3;
         c = (m_cur - 1) % 3;
         if (b[4]) begin
            if (m_b[m_cur-1] == 2'b00) begin
               m_b[m_cur-1] = m_turn; m_gs = 2'b01; m_tmr = TO; acc = 1'b1;
            end
         end else if (b[3]) r = (r + 2) % 3;
         else if (b[2]) r = (r + 1) % 3;
         else if (b[1]) c = (c + 2) % 3;
         else if (b[0]) c = (c + 1) % 3;
         m_cur = r * 3 + c + 1;
         if (!acc) begin
            if (m_tmr == 0) begin m_turn = m_flip(m_turn); m_tmr = TO; end
            else m_tmr--;
         end
      end else if (m_gs == 2'b01) begin
         w = m_line_winner();
         full = 1'b1;
         for (int i = 0; i < 9; i++) if (m_b[i] == 2'b00) full = 1'b0;
         if (w != 2'b00) begin m_gs = 2'b10; m_win = w; end
         else if (full) m_gs = 2'b11;
         else begin m_gs = 2'b00; m_turn = m_flip(m_turn); end
      end
   endtask

   typedef struct {
      int         id;
      logic [17:0] pos;
      logic [3:0] cur;
      logic [1:0] turn, gs, win;
   } snap_t;

   snap_t sb_q[$];

   function automatic snap_t m_snap(input int id);
      snap_t s;
      s.id = id;
      for (int i = 0; i < 9; i++) s.pos[2*i +: 2] = m_b[i];
      s.cur = 4'(m_cur); s.turn = m_turn; s.gs = m_gs; s.win = m_win;
      return s;
   endfunction

   task automatic compare(input snap_t e);
      chk($sformatf("s%0d_pos", e.id), 32'({pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1}), 32'(e.pos));
      chk($sformatf("s%0d_cursor", e.id), 32'(cursor), 32'(e.cur));
      chk($sformatf("s%0d_turn", e.id), 32'(turn), 32'(e.turn));
      chk($sformatf("s%0d_state", e.id), 32'(game_state), 32'(e.gs));
      chk($sformatf("s%0d_winner", e.id), 32'(winner), 32'(e.win));
   endtask

   // Monitor: compare registered outputs just after each active edge
   always @(posedge clk) begin
      #1;
      while (sb_q.size() > 0) compare(sb_q.pop_front());
   end

   // One clock of stimulus; starts and ends at a falling edge
   task automatic step(input logic [5:0] b);
      {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
      m_step(b);
      step_id++;
      sb_q.push_back(m_snap(step_id));
      @(posedge clk);
      #2;
      {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
      @(negedge clk);
   endtask

   task automatic goto(input int t);
      for (int k = 0; k < 2 && ((m_cur - 1) / 3) != ((t - 1) / 3); k++) step(B_DOWN);
      for (int k = 0; k < 2 && ((m_cur - 1) % 3) != ((t - 1) % 3); k++) step(B_RIGHT);
   endtask

   task automatic mv(input int t);
      goto(t);
      step(B_SEL);
      step(B_NONE);
   endtask

   int draw_ord [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
   int win9_ord [9] = '{2, 1, 4, 3, 7, 5, 8, 6, 9};
   logic [5:0] rb;

   initial begin
      reset = 1'b0;
      {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
      m_reset();
      repeat (2) @(negedge clk);
      compare(m_snap(0));
      reset = 1'b1;

      // place at 5, move right, place at 6
      step(B_SEL); step(B_NONE); step(B_RIGHT); step(B_SEL); step(B_NONE);
      chk("basic_pos5", 32'(pos5), 32'd1);
      chk("basic_pos6", 32'(pos6), 32'd2);
      chk("basic_turn", 32'(turn), 32'd1);
      chk("basic_state", 32'(game_state), 32'd0);

      // idle timeout toggles turn once
      step(B_NEW);
      repeat (11) step(B_NONE);
      chk("timeout_turn", 32'(turn), 32'd2);
      chk("timeout_board", 32'({pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1}), 32'd0);

      // select in the expiry cycle wins over the timeout
      step(B_NEW);
      repeat (10) step(B_NONE);
      step(B_SEL);
      chk("expiry_sel_pos5", 32'(pos5), 32'd1);
      chk("expiry_sel_turn", 32'(turn), 32'd1);
      step(B_NONE);

      // cursor wrap and direction priority
      step(B_NEW);
      step(B_UP); step(B_RIGHT); step(B_RIGHT);
      chk("wrap_right", 32'(cursor), 32'd1);
      step(B_DOWN); step(B_DOWN); step(B_DOWN);
      chk("wrap_down", 32'(cursor), 32'd1);
      step(B_UP | B_LEFT);
      chk("prio_up", 32'(cursor), 32'd7);

      // select with direction, occupied cell, new with select
      step(B_NEW);
      step(B_SEL | B_RIGHT);
      chk("seldir_cursor", 32'(cursor), 32'd5);
      step(B_NONE);
      step(B_SEL);
      chk("occ_pos5", 32'(pos5), 32'd1);
      chk("occ_state", 32'(game_state), 32'd0);
      chk("occ_turn", 32'(turn), 32'd2);
      step(B_NEW | B_SEL);
      chk("new_sel_pos5", 32'(pos5), 32'd0);

      // P1 wins on the top row
      step(B_NEW);
      mv(1); mv(4); mv(2); mv(5);
      goto(3); step(B_SEL); step(B_NONE);
      chk("win_state", 32'(game_state), 32'd2);
      chk("win_winner", 32'(winner), 32'd1);
      step(B_LEFT); step(B_SEL);
      chk("win_frozen_cursor", 32'(cursor), 32'd3);

      // draw, then win on the ninth move
      step(B_NEW);
      foreach (draw_ord[i]) mv(draw_ord[i]);
      chk("draw_state", 32'(game_state), 32'd3);
      chk("draw_winner", 32'(winner), 32'd0);
      step(B_NEW);
      foreach (win9_ord[i]) mv(win9_ord[i]);
      chk("win9_state", 32'(game_state), 32'd2);
      chk("win9_winner", 32'(winner), 32'd1);

      // reset asserted during CHECK
      step(B_NEW);
      step(B_SEL);
      chk("pre_reset_check", 32'(game_state), 32'd1);
      reset = 1'b0;
      m_reset();
      #1;
      compare(m_snap(-1));
      @(negedge clk);
      reset = 1'b1;
      step(B_NONE);

      // random button traffic
      for (int i = 0; i < 150; i++) begin
         rb = 6'($urandom_range(0, 31));
         if ($urandom_range(0, 24) == 0) rb[5] = 1'b1;
         step(rb);
      end

      #3;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 The block SHALL have parameter FIRST_PLAYER, default 2'b01, giving the player who moves first after reset or a new game.
REQ-002 The block SHALL have parameter TURN_TIMEOUT, default 32'd250_000_000, giving the clk cycles allowed per turn; 0 disables the turn timer.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port btn_up / btn_down / btn_left / btn_right, inputs, 1 bit each: single-cycle, already-debounced cursor-move pulses.
REQ-006 The block SHALL have port btn_sel, input, 1 bit: single-cycle pulse that places a mark at the cursor.
REQ-007 The block SHALL have port btn_new, input, 1 bit: single-cycle pulse that starts a new game.
REQ-008 The block SHALL have ports pos1..pos9, outputs, 2 bits each: cell states, row-major with pos1 top-left; 00 empty, 01 player 1 (red), 10 player 2 (green); 11 is never driven.
REQ-009 The block SHALL have port cursor, output, 4 bits: selected cell index, 1..9.
REQ-010 The block SHALL have port turn, output, 2 bits: player to move (01/10).
REQ-011 The block SHALL have port game_state, output, 2 bits: PLAY=00, CHECK=01, WIN=10, DRAW=11.
REQ-012 The block SHALL have port winner, output, 2 bits: the winning player's code in WIN, else 00.

Function
REQ-013 In PLAY, a btn_sel pulse on an empty cursor cell SHALL write turn into that cell on the next clk edge and enter CHECK.
REQ-014 In PLAY, a btn_sel pulse on an occupied cell SHALL be ignored: no state, turn or board change.
REQ-015 CHECK SHALL last exactly one cycle and evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board.
REQ-016 Leaving CHECK, the block SHALL go to WIN if any line holds three equal non-00 cells, else to DRAW if all 9 cells are non-00, else to PLAY with turn toggled.
REQ-017 WIN SHALL take priority over DRAW when the ninth move completes a line.
REQ-018 The cursor SHALL move one cell per direction pulse and wrap within its row (right from column 3 goes to column 1) or column (down from row 3 goes to row 1).
REQ-019 Simultaneous direction pulses SHALL be resolved by priority up > down > left > right; only one move SHALL apply.
REQ-020 btn_sel together with a direction pulse in the same cycle SHALL place the mark at the old cursor and SHALL discard the direction pulse.
REQ-021 Cursor movement SHALL be allowed in PLAY only; all button inputs except btn_new SHALL be ignored in CHECK, WIN and DRAW.
REQ-022 btn_new SHALL, from any state, on the next edge clear all cells to 00, set cursor to 5, set turn to FIRST_PLAYER, set winner to 00, reload the turn timer and enter PLAY.
REQ-023 btn_new SHALL take priority over every other input in the same cycle.
REQ-024 The 32-bit turn timer SHALL reload to TURN_TIMEOUT on entry to PLAY and count down once per cycle in PLAY.
REQ-025 On timer expiry (reaching 0 with no accepted move), the block SHALL toggle turn and reload the timer, with no board change.
REQ-026 An accepted btn_sel in the expiry cycle SHALL take priority over the timeout.
REQ-027 With TURN_TIMEOUT = 0, the timer SHALL be held idle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset assertion SHALL asynchronously force: pos1..pos9 = 00, cursor = 5, turn = FIRST_PLAYER, game_state = PLAY, winner = 00, timer = TURN_TIMEOUT.
REQ-030 Reset asserted mid-game, including during CHECK, SHALL discard any pending move; deassertion SHALL take effect at the first clk edge with reset high.

Structure
REQ-031 Package ttt_pkg SHALL hold the cell encodings (EMPTY, P1, P2), the game_state encodings and the 8-line cell-index table.
REQ-032 The line evaluation SHALL be a combinational sub-module ttt_line_check, taking the 9 cells and returning a win flag, the winner code and a full flag.
REQ-033 The state machine, cursor logic and timer SHALL reside in ttt_game_ctrl.

Verification
REQ-034 After reset, pulses of btn_sel at cursor 5 then btn_right then btn_sel SHALL give pos5=01, pos6=10 and turn=01, with game_state=PLAY.
REQ-035 P1 takes cells 1,2,3 and P2 takes cells 4,5 in alternation: one cycle after pos3 is written, game_state SHALL be WIN and winner SHALL be 01, and later btn_sel pulses SHALL be ignored.
REQ-036 Nine moves with no line (order 1,2,3,5,4,6,8,7,9) SHALL end in DRAW with winner=00; a variant in which the ninth move completes a line SHALL end in WIN.
REQ-037 With cursor at 3, btn_right SHALL give cursor 1; with cursor at 7, btn_down SHALL give cursor 1; with btn_up and btn_left in the same cycle, only up SHALL apply.
REQ-038 btn_sel on an occupied cell SHALL change nothing; btn_new in the same cycle as btn_sel SHALL clear the board.
REQ-039 With TURN_TIMEOUT=10 and no input for 11 cycles in PLAY, turn SHALL toggle once and the board SHALL be unchanged; reset asserted during CHECK SHALL return all outputs to their reset values.
